// File: rtl/divider_32_bit_pkg.sv
// Shared constants for the 32-bit restoring divider: operand width,
// iteration count and the FSM state encoding.
package divider_32_bit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int CNT_W     = $clog2(DIV_ITER + 1);

  // State enumeration of the divider FSM.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/divider_32_bit_adder.sv
// 32-bit ripple-style adder with carry in/out and signed overflow flag.
// The divider uses it as a subtractor (A + ~B + 1).
module adder_32_bit
  import divider_32_bit_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] A,
  input  logic [DIV_WIDTH-1:0] B,
  input  logic                 Cin,
  output logic [DIV_WIDTH-1:0] Sum,
  output logic                 Cout,
  output logic                 Overflow
);

  logic [DIV_WIDTH:0] full_sum;

  // Widened sum so the carry out falls into the top bit.
  assign full_sum = {1'b0, A} + {1'b0, B} + {{DIV_WIDTH{1'b0}}, Cin};
  assign Sum      = full_sum[DIV_WIDTH-1:0];
  assign Cout     = full_sum[DIV_WIDTH];
  // Signed overflow: operands agree in sign, result does not.
  assign Overflow = (A[DIV_WIDTH-1] == B[DIV_WIDTH-1]) &&
                    (Sum[DIV_WIDTH-1] != A[DIV_WIDTH-1]);

endmodule

// File: rtl/divider_32_bit.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle.
// Handshake: start is accepted only in IDLE or DONE; busy is high for the
// 32 iteration cycles after the accepting edge, and done pulses for exactly
// one cycle when quotient/remainder/div_by_zero become valid. A start seen
// while busy is dropped, never queued.
module divider_32_bit
  import divider_32_bit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // dvd_q doubles as the quotient shift register: dividend bits leave at the
  // MSB while quotient bits enter at the LSB.
  logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0] quo_q, quo_d;
  logic [DIV_WIDTH-1:0] rmd_q, rmd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [DIV_WIDTH:0]   trial;
  logic [DIV_WIDTH-1:0] diff;
  logic                 cout;
  logic                 ovf_unused;
  logic                 no_borrow;
  logic                 accept;
  logic [DIV_WIDTH-1:0] step_rem;
  logic [DIV_WIDTH-1:0] step_quo;

  // 33-bit trial value: partial remainder with the next dividend bit.
  assign trial = {rem_q, dvd_q[DIV_WIDTH-1]};

  adder_32_bit u_sub (
    .A        (trial[DIV_WIDTH-1:0]),
    .B        (~dvs_q),
    .Cin      (1'b1),
    .Sum      (diff),
    .Cout     (cout),
    .Overflow (ovf_unused)
  );

  // A set trial MSB means trial >= 2^32 > divisor, so subtraction is always
  // legal then; the low 32 bits of the difference are still exact because
  // the result is below the divisor.
  assign no_borrow = cout | trial[DIV_WIDTH];
  assign step_rem  = no_borrow ? diff : trial[DIV_WIDTH-1:0];
  assign step_quo  = {dvd_q[DIV_WIDTH-2:0], no_borrow};
  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state logic: FSM, iteration counter and datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    if (accept) begin
      state_d = ST_DIVIDE;
      cnt_d   = CNT_W'(DIV_ITER);
      dvd_d   = dividend;
      dvs_d   = divisor;
      rem_d   = '0;
      busy_d  = 1'b1;
      dbz_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_DIVIDE: begin
          rem_d = step_rem;
          dvd_d = step_quo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quo_d   = step_quo;
            rmd_d   = step_rem;
            dbz_d   = (dvs_q == '0);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous abort on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/divider_32_bit.md
DIVIDER_32_BIT -- requirements
Module: divider_32_bit

Interface
Parameters: none; operand width is fixed at 32 bits.
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request to begin a division; sampled only in IDLE or DONE.
REQ-004 SHALL have port: dividend  input  32  unsigned dividend; sampled on the accepting edge only.
REQ-005 SHALL have port: divisor  input  32  unsigned divisor; sampled on the accepting edge only.
REQ-006 SHALL have port: quotient  output  32  unsigned quotient, registered.
REQ-007 SHALL have port: remainder  output  32  unsigned remainder, registered.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port: done  output  1  single-cycle pulse; high when the results become valid.
REQ-010 SHALL have port: div_by_zero  output  1  high with done when the captured divisor was 0; held until the next accept.

Function
REQ-011 SHALL implement states IDLE, DIVIDE and DONE.
REQ-012 Transitions SHALL be:
- IDLE to DIVIDE on start.
- DIVIDE to DONE after 32 iterations.
- DONE to DIVIDE if start is high, otherwise DONE to IDLE.
REQ-013 On accept, the block SHALL capture dividend and divisor, clear the partial remainder, load the iteration counter with 32, and set busy on the next cycle.
REQ-014 Each DIVIDE cycle SHALL perform one unsigned restoring step, MSB first:
- shift the next dividend bit into the partial remainder (33-bit trial value);
- subtract when the trial value is at least the divisor;
- shift the resulting quotient bit in at the LSB.
REQ-015 The subtraction SHALL be computed as trial + ~divisor + 1 through the adder sub-module; no-borrow is Cout=1, or bit 32 of the trial value set.
REQ-016 Latency SHALL be fixed: accept at edge N, busy high for cycles N+1 to N+32, done high in cycle N+33.
REQ-017 In the done cycle, quotient = floor(dividend/divisor) and remainder = dividend mod divisor.
REQ-018 With divisor = 0, the block SHALL use the same 33-cycle latency and produce quotient = 32'hFFFFFFFF, remainder = dividend, div_by_zero = 1.
REQ-019 A start asserted while busy SHALL be ignored; no queuing.
REQ-020 A start asserted in the DONE cycle SHALL be accepted, giving back-to-back operations every 33 cycles.
REQ-021 quotient and remainder SHALL hold their last values until the next accept; they are undefined-but-stable while busy.
REQ-022 busy and done SHALL never be high in the same cycle.

Reset
REQ-023 reset SHALL asynchronously force:
- state = IDLE;
- quotient = 0 and remainder = 0;
- busy = 0, done = 0 and div_by_zero = 0;
- counter = 0.
REQ-024 A reset asserted mid-DIVIDE SHALL abort the operation; no done pulse SHALL follow after release.
REQ-025 After reset deassertion, the first start SHALL be accepted on the first rising edge.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE, DIVIDE, DONE), the constant DIV_WIDTH = 32 and the constant DIV_ITER = 32.
REQ-027 The subtractor SHALL be one instance of the existing adder_32_bit, with ports A, B, Cin, Sum, Cout and Overflow; Overflow is left unused.
REQ-028 No other sub-modules SHALL be used; the FSM, counter and shift registers reside in divider_32_bit.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Basic: dividend=20, divisor=8 -> quotient=2, remainder=4, done exactly 33 cycles after accept.
- Divide by zero: dividend=32'h12345678, divisor=0 -> quotient=32'hFFFFFFFF, remainder=32'h12345678, div_by_zero=1.
- Large operands: dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0; dividend=7, divisor=32'hFFFFFFFF -> quotient=0, remainder=7.
- Back-to-back: start held high through DONE, operations 100/7 then 81/9 -> 14 r2, then 9 r0, with done pulses 33 cycles apart.
- Start while busy: start pulsed at cycle 10 of an operation with new operands -> ignored, original result unchanged, a single done pulse.
- Reset mid-operation: reset asserted at cycle 15 of DIVIDE -> all outputs 0 immediately, no done pulse after release, next 20/8 gives 2 r4.
